regs: RTL and testbench
=======================

Name: regs

Overview:
- Integer register file: x0..x31, 32-bit.
- Consumes the writeback triple (rd_addr/rd_data/rd_wen) produced by the execute stage.
- Serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Also provides a registered debug read port and a committed-write counter for bring-up and trace.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width (2^ADDR_W registers).
- BYPASS_EN, 1, 1 = forward the in-flight write to the read ports; 0 = reads return stored value only.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- reg1_raddr_i  input  ADDR_W  read port 1 index (rs1 from decode).
- reg2_raddr_i  input  ADDR_W  read port 2 index (rs2 from decode).
- reg1_rdata_o  output  DATA_W  read port 1 data, combinational.
- reg2_rdata_o  output  DATA_W  read port 2 data, combinational.
- reg_waddr_i  input  ADDR_W  write index (rd_addr from execute).
- reg_wdata_i  input  DATA_W  write data (rd_data from execute).
- reg_wen_i  input  1  write enable (rd_wen from execute).
- dbg_raddr_i  input  ADDR_W  debug read index.
- dbg_rdata_o  output  DATA_W  debug read data, registered, 1-cycle latency.
- wr_cnt_o  output  32  count of committed writes to x1..x31.

Behaviour:
- Reset (rst=1, asynchronous assert, released synchronously by the source):
  - All storage x1..x31 = 0.
  - dbg_rdata_o = 0, wr_cnt_o = 0.
  - reg1_rdata_o/reg2_rdata_o follow the read rules (0 for any index while storage is 0).
  - Reset asserted mid-write: the write is lost; all state is cleared immediately.
- x0 is hardwired zero:
  - No storage flop exists for x0.
  - A write with reg_waddr_i=0 is discarded and does not increment wr_cnt_o.
  - Reads of index 0 return 0 on every port, even during a write to 0.
- Write: on the rising clk edge, with rst=0, reg_wen_i=1 and reg_waddr_i!=0, mem[reg_waddr_i] <= reg_wdata_i.
- Read ports 1 and 2 are combinational, zero-cycle. For each port:
  - raddr==0 -> 0.
  - Else BYPASS_EN=1 and reg_wen_i=1 and reg_waddr_i==raddr -> reg_wdata_i (write-first forwarding).
  - Else -> mem[raddr].
  - Both ports may read the same index; each applies the same rule independently.
- Bypass uses only the current-cycle write inputs. No earlier writes are held in flight; they are already in storage.
- Debug port:
  - On each rising edge, dbg_rdata_o <= value of dbg_raddr_i under the same rules as the read ports (including bypass and the x0 rule).
  - The value is therefore visible the cycle after the address is presented.
- wr_cnt_o:
  - Increments by 1 on every edge that performs a committed write (wen=1, waddr!=0).
  - Wraps from 0xFFFF_FFFF to 0 with no flag.
  - reg_wen_i=0 leaves it unchanged, regardless of address/data.
- Writes with reg_wen_i=0 never alter storage or counters, whatever address or data is presented.
- There is no X-propagation into storage: writes are gated solely by reg_wen_i and the address.
- No stall/hold input: the pipeline controller stalls by deasserting reg_wen_i.

Test Plan:
- Reset then read: assert rst; reg1_raddr_i=5, reg2_raddr_i=31 -> both rdata=0; wr_cnt_o=0; dbg_rdata_o=0.
- Write/read-back: cycle 1 writes x3=0x0000_0010 (wen=1). Cycle 2 reads reg1_raddr_i=3 with wen=0 -> 0x0000_0010. wr_cnt_o=1.
- Bypass:
  - x7 holds 0x1111_1111. In the same cycle present wen=1, waddr=7, wdata=0xDEAD_BEEF, reg1_raddr_i=7, reg2_raddr_i=7 -> both rdata=0xDEAD_BEEF before the edge.
  - With BYPASS_EN=0 the same stimulus gives 0x1111_1111 before the edge and 0xDEAD_BEEF after it.
- x0 protection: wen=1, waddr=0, wdata=0xFFFF_FFFF; reg1_raddr_i=0 -> 0 during and after the write; wr_cnt_o unchanged; dbg read of 0 -> 0.
- Debug latency: x10=0xA5A5_0000; dbg_raddr_i=10 in cycle N -> dbg_rdata_o=0xA5A5_0000 in cycle N+1, not before.
- Reset mid-operation and counter wrap:
  - Write x4=0x1234 and assert rst asynchronously between edges -> x4 reads 0 immediately, wr_cnt_o=0.
  - Force wr_cnt_o=0xFFFF_FFFF, then one committed write -> wr_cnt_o=0.

Source files
------------

// File: rtl/regs.sv
// Integer register file x0..x31 with two combinational read ports,
// same-cycle write-to-read bypass, a registered debug read port and a
// counter of committed writes. x0 has no storage and always reads zero.
module regs #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] reg1_raddr_i,
   input  logic [ADDR_W-1:0] reg2_raddr_i,
   output logic [DATA_W-1:0] reg1_rdata_o,
   output logic [DATA_W-1:0] reg2_rdata_o,
   input  logic [ADDR_W-1:0] reg_waddr_i,
   input  logic [DATA_W-1:0] reg_wdata_i,
   input  logic              reg_wen_i,
   input  logic [ADDR_W-1:0] dbg_raddr_i,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic [31:0]       wr_cnt_o
);

   localparam int NumRegs = 1 << ADDR_W;

   // Storage starts at index 1: x0 is a constant, not a flop.
   logic [DATA_W-1:0] mem_q [1:NumRegs-1];
   logic [DATA_W-1:0] dbgRdata_q, dbgRdata_d;
   logic [31:0]       wrCnt_q, wrCnt_d;
   logic              wrCommit;
   logic [DATA_W-1:0] rdata1, rdata2;

   // Shared read rule for every port: x0 first, then the in-flight write
   // (when forwarding is enabled), otherwise the stored value.
   function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] raddr);
      logic [DATA_W-1:0] value;
      value = '0;
      if (raddr == '0) begin
         value = '0;
      end else if (BYPASS_EN && reg_wen_i && (reg_waddr_i == raddr)) begin
         value = reg_wdata_i;
      end else begin
         value = mem_q[raddr];
      end
      return value;
   endfunction

   // A write only commits when enabled and aimed at a real register.
   always_comb begin
      wrCommit = reg_wen_i && (reg_waddr_i != '0);
   end

   // Combinational read ports and next-state for debug data and counter.
   always_comb begin
      rdata1     = readPort(reg1_raddr_i);
      rdata2     = readPort(reg2_raddr_i);
      dbgRdata_d = readPort(dbg_raddr_i);
      wrCnt_d    = wrCommit ? (wrCnt_q + 32'd1) : wrCnt_q;
   end

   // Register storage; reset wipes every register, including one being written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NumRegs; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wrCommit) begin
         mem_q[reg_waddr_i] <= reg_wdata_i;
      end
   end

   // Debug read data and committed-write counter; the counter wraps silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbgRdata_q <= '0;
         wrCnt_q    <= '0;
      end else begin
         dbgRdata_q <= dbgRdata_d;
         wrCnt_q    <= wrCnt_d;
      end
   end

   assign reg1_rdata_o = rdata1;
   assign reg2_rdata_o = rdata2;
   assign dbg_rdata_o  = dbgRdata_q;
   assign wr_cnt_o     = wrCnt_q;

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: a forwarding instance and a non-forwarding
// instance share all inputs; table vectors check the read ports and counter,
// a queue carries expected debug data to the following cycle, and short
// hand-written sequences cover latency, mid-write reset and counter wrap.
module tb_regs;

   logic        clk;
   logic        rst;
   logic [4:0]  reg1Raddr, reg2Raddr, regWaddr, dbgRaddr;
   logic [31:0] regWdata;
   logic        regWen;

   logic [31:0] rdata1, rdata2, dbgRdata, wrCnt;
   logic [31:0] rdata1Nb, rdata2Nb, dbgRdataNb, wrCntNb;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  raddr1;
      logic [4:0]  raddr2;
      logic [31:0] exp1;
      logic [31:0] exp2;
      logic [31:0] exp1Nb;
      logic [31:0] exp2Nb;
      logic [31:0] expCnt;
   } vec_t;

   vec_t vecs [0:10];

   logic [31:0] dbgExpQ[$];
   logic [31:0] dbgExpNbQ[$];

   regs #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .reg1_raddr_i (reg1Raddr),
      .reg2_raddr_i (reg2Raddr),
      .reg1_rdata_o (rdata1),
      .reg2_rdata_o (rdata2),
      .reg_waddr_i  (regWaddr),
      .reg_wdata_i  (regWdata),
      .reg_wen_i    (regWen),
      .dbg_raddr_i  (dbgRaddr),
      .dbg_rdata_o  (dbgRdata),
      .wr_cnt_o     (wrCnt)
   );

   regs #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b0)) dutNb (
      .clk          (clk),
      .rst          (rst),
      .reg1_raddr_i (reg1Raddr),
      .reg2_raddr_i (reg2Raddr),
      .reg1_rdata_o (rdata1Nb),
      .reg2_rdata_o (rdata2Nb),
      .reg_waddr_i  (regWaddr),
      .reg_wdata_i  (regWdata),
      .reg_wen_i    (regWen),
      .dbg_raddr_i  (dbgRaddr),
      .dbg_rdata_o  (dbgRdataNb),
      .wr_cnt_o     (wrCntNb)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      regWen    = v.wen;
      regWaddr  = v.waddr;
      regWdata  = v.wdata;
      reg1Raddr = v.raddr1;
      reg2Raddr = v.raddr2;
      dbgRaddr  = v.raddr1;
      dbgExpQ.push_back(v.exp1);
      dbgExpNbQ.push_back(v.exp1Nb);
   endtask

   task automatic popDebug(input int idx);
      if (dbgExpQ.size() == 0 || dbgExpNbQ.size() == 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL dbgQueue[%0d]: got empty queue, expected a pending entry", idx);
      end else begin
         checkOutput($sformatf("dbg[%0d]", idx), dbgRdata, dbgExpQ.pop_front());
         checkOutput($sformatf("dbgNb[%0d]", idx), dbgRdataNb, dbgExpNbQ.pop_front());
      end
   endtask

   initial begin
      //                wen   waddr  wdata          r1     r2     exp1           exp2           exp1Nb         exp2Nb         cnt
      vecs[0]  = '{1'b1, 5'd3,  32'h0000_0010, 5'd3,  5'd0,  32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'd1};
      vecs[1]  = '{1'b0, 5'd3,  32'h0000_FFFF, 5'd3,  5'd3,  32'h0000_0010, 32'h0000_0010, 32'h0000_0010, 32'h0000_0010, 32'd1};
      vecs[2]  = '{1'b1, 5'd7,  32'h1111_1111, 5'd7,  5'd3,  32'h1111_1111, 32'h0000_0010, 32'h0000_0000, 32'h0000_0010, 32'd2};
      vecs[3]  = '{1'b1, 5'd7,  32'hDEAD_BEEF, 5'd7,  5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1111_1111, 32'h1111_1111, 32'd3};
      vecs[4]  = '{1'b0, 5'd7,  32'h0000_0000, 5'd7,  5'd0,  32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'd3};
      vecs[5]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'd3};
      vecs[6]  = '{1'b0, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd3,  32'h0000_0000, 32'h0000_0010, 32'h0000_0000, 32'h0000_0010, 32'd3};
      vecs[7]  = '{1'b1, 5'd10, 32'hA5A5_0000, 5'd10, 5'd31, 32'hA5A5_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'd4};
      vecs[8]  = '{1'b0, 5'd31, 32'h1234_5678, 5'd31, 5'd10, 32'h0000_0000, 32'hA5A5_0000, 32'h0000_0000, 32'hA5A5_0000, 32'd4};
      vecs[9]  = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd7,  32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'd5};
      vecs[10] = '{1'b0, 5'd31, 32'h0000_0000, 5'd31, 5'd3,  32'hCAFE_F00D, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0010, 32'd5};

      // Reset state.
      rst       = 1'b1;
      regWen    = 1'b0;
      regWaddr  = 5'd0;
      regWdata  = 32'h0;
      reg1Raddr = 5'd5;
      reg2Raddr = 5'd31;
      dbgRaddr  = 5'd0;
      @(posedge clk);
      #1;
      checkOutput("resetRd1", rdata1, 32'h0);
      checkOutput("resetRd2", rdata2, 32'h0);
      checkOutput("resetCnt", wrCnt, 32'h0);
      checkOutput("resetDbg", dbgRdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Table vectors: read ports before the edge, debug and counter after it.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("rd1[%0d]", i), rdata1, vecs[i].exp1);
         checkOutput($sformatf("rd2[%0d]", i), rdata2, vecs[i].exp2);
         checkOutput($sformatf("rd1Nb[%0d]", i), rdata1Nb, vecs[i].exp1Nb);
         checkOutput($sformatf("rd2Nb[%0d]", i), rdata2Nb, vecs[i].exp2Nb);
         @(posedge clk);
         #1;
         popDebug(i);
         checkOutput($sformatf("cnt[%0d]", i), wrCnt, vecs[i].expCnt);
         checkOutput($sformatf("cntNb[%0d]", i), wrCntNb, vecs[i].expCnt);
         @(negedge clk);
      end

      // Non-forwarding instance sees the x7 write once it has landed.
      reg1Raddr = 5'd7;
      #1;
      checkOutput("nbAfterEdge", rdata1Nb, 32'hDEAD_BEEF);

      // Debug latency: new address shows up only after the next edge.
      regWen   = 1'b0;
      dbgRaddr = 5'd10;
      #1;
      checkOutput("dbgLatBefore", dbgRdata, 32'hCAFE_F00D);
      @(posedge clk);
      #1;
      checkOutput("dbgLatAfter", dbgRdata, 32'hA5A5_0000);
      @(negedge clk);

      // Write to x0 with debug looking at x0.
      regWen    = 1'b1;
      regWaddr  = 5'd0;
      regWdata  = 32'hFFFF_FFFF;
      reg1Raddr = 5'd0;
      dbgRaddr  = 5'd0;
      @(posedge clk);
      #1;
      checkOutput("x0After", rdata1, 32'h0);
      checkOutput("x0Dbg", dbgRdata, 32'h0);
      checkOutput("x0Cnt", wrCnt, 32'd5);
      @(negedge clk);

      // Reset between edges after a write to x4.
      regWen    = 1'b1;
      regWaddr  = 5'd4;
      regWdata  = 32'h0000_1234;
      reg1Raddr = 5'd4;
      reg2Raddr = 5'd31;
      dbgRaddr  = 5'd31;
      @(posedge clk);
      #1;
      regWen = 1'b0;
      #1;
      checkOutput("x4Stored", rdata1, 32'h0000_1234);
      checkOutput("cntBeforeRst", wrCnt, 32'd6);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("x4AfterRst", rdata1, 32'h0);
      checkOutput("x31AfterRst", rdata2, 32'h0);
      checkOutput("cntAfterRst", wrCnt, 32'h0);
      checkOutput("dbgAfterRst", dbgRdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Counter wrap: preload the counter to all ones, then one committed write.
      force dut.wrCnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.wrCnt_q;
      regWen   = 1'b1;
      regWaddr = 5'd5;
      regWdata = 32'h0000_0001;
      @(posedge clk);
      #1;
      checkOutput("cntWrap", wrCnt, 32'h0);
      checkOutput("cntNbAfterRst", wrCntNb, 32'd1);
      @(negedge clk);

      // Disabled write leaves storage and counter alone.
      regWen    = 1'b0;
      regWaddr  = 5'd5;
      regWdata  = 32'h9999_9999;
      reg1Raddr = 5'd5;
      @(posedge clk);
      #1;
      checkOutput("wenOffData", rdata1, 32'h0000_0001);
      checkOutput("wenOffCnt", wrCnt, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
